// File: rtl/bus_transfer_sequencer.sv
// Round-robin bus transfer sequencer: IDLE -> DRIVE -> LOAD per register-to-register move.
// Build option: define BUSSEQ_FIXED_PRIORITY_EN for fixed priority (requester 0 highest).
module bus_transfer_sequencer #(
    parameter int NREQ  = 4,
    parameter int NSRC  = 8,
    parameter int NDST  = 8,
    parameter int SRC_W = 3,
    parameter int DST_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*SRC_W-1:0] src,
    input  logic [NREQ*DST_W-1:0] dst,
    output logic [NREQ-1:0]       ack,
    output logic [NSRC-1:0]       bus_en,
    output logic [NDST-1:0]       bus_load,
    output logic                  busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;

    logic [1:0]       r_state;
    logic [PTR_W-1:0] r_grant;
    logic [SRC_W-1:0] r_src_l;
    logic [DST_W-1:0] r_dst_l;
    logic [NREQ-1:0]  r_ack;
    logic [NSRC-1:0]  r_bus_en;
    logic [NDST-1:0]  r_bus_load;
    logic             r_busy;
`ifndef BUSSEQ_FIXED_PRIORITY_EN
    logic [PTR_W-1:0] r_rr_ptr;
`endif

    logic             w_found;
    logic [PTR_W-1:0] w_grant;
    int               w_idx;
    logic [SRC_W-1:0] w_src_sel;
    logic [DST_W-1:0] w_dst_sel;

    // Out-of-range indices decode to all-zero, so the bus floats / nothing loads.
    function automatic logic [NSRC-1:0] dec_src(input logic [SRC_W-1:0] s);
        logic [NSRC-1:0] v;
        v = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(s) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [NDST-1:0] dec_dst(input logic [DST_W-1:0] d);
        logic [NDST-1:0] v;
        v = '0;
        for (int i = 0; i < NDST; i++) begin
            if (int'(d) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef BUSSEQ_FIXED_PRIORITY_EN
            w_idx = i;
`else
            w_idx = int'(r_rr_ptr) + i;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
`endif
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_grant = PTR_W'(w_idx);
            end
        end
        w_src_sel = src[int'(w_grant)*SRC_W +: SRC_W];
        w_dst_sel = dst[int'(w_grant)*DST_W +: DST_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_src_l    <= '0;
            r_dst_l    <= '0;
            r_ack      <= '0;
            r_bus_en   <= '0;
            r_bus_load <= '0;
            r_busy     <= 1'b0;
`ifndef BUSSEQ_FIXED_PRIORITY_EN
            r_rr_ptr   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack      <= '0;
                    r_bus_load <= '0;
                    if (w_found) begin
                        r_state  <= S_DRIVE;
                        r_grant  <= w_grant;
                        r_src_l  <= w_src_sel;
                        r_dst_l  <= w_dst_sel;
                        r_bus_en <= dec_src(w_src_sel);
                        r_busy   <= 1'b1;
                    end else begin
                        r_bus_en <= '0;
                        r_busy   <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    // Source has driven a full cycle; the load edge closes the LOAD cycle.
                    r_state        <= S_LOAD;
                    r_bus_en       <= dec_src(r_src_l);
                    r_bus_load     <= dec_dst(r_dst_l);
                    r_ack          <= '0;
                    r_ack[r_grant] <= 1'b1;
                    r_busy         <= 1'b1;
                end
                S_LOAD: begin
                    r_state    <= S_IDLE;
                    r_ack      <= '0;
                    r_bus_en   <= '0;
                    r_bus_load <= '0;
                    r_busy     <= 1'b0;
`ifndef BUSSEQ_FIXED_PRIORITY_EN
                    if (int'(r_grant) == NREQ - 1) r_rr_ptr <= '0;
                    else                           r_rr_ptr <= r_grant + 1'b1;
`endif
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_ack      <= '0;
                    r_bus_en   <= '0;
                    r_bus_load <= '0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign bus_en   = r_bus_en;
    assign bus_load = r_bus_load;
    assign busy     = r_busy;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed bench for bus_transfer_sequencer with a small register-file model on the bus.
module tb_bus_transfer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] src, dst;
    logic [3:0]  ack;
    logic [7:0]  bus_en, bus_load;
    logic        busy;

    logic [3:0]  req2;
    logic [11:0] src2, dst2;
    logic [3:0]  ack2;
    logic [5:0]  bus_en2;
    logic [7:0]  bus_load2;
    logic        busy2;

    logic [15:0] regs [8];
    logic [15:0] bus_val;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bus_transfer_sequencer dut (
        .clk(clk), .reset(reset), .req(req), .src(src), .dst(dst),
        .ack(ack), .bus_en(bus_en), .bus_load(bus_load), .busy(busy)
    );

    bus_transfer_sequencer #(.NSRC(6)) dut_oor (
        .clk(clk), .reset(reset), .req(req2), .src(src2), .dst(dst2),
        .ack(ack2), .bus_en(bus_en2), .bus_load(bus_load2), .busy(busy2)
    );

    always_comb begin
        bus_val = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (bus_en[i]) bus_val = regs[i];
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h1000 + 16'(i);
            regs[2] <= 16'hBEEF;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (bus_load[i]) regs[i] <= bus_val;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        req = '0; src = '0; dst = '0;
        req2 = '0; src2 = '0; dst2 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({ack, bus_en, bus_load, busy} !== 21'd0) begin
                $display("FAIL reset_idle[%0d]: ack=%b bus_en=%h bus_load=%h busy=%b, want all 0",
                         c, ack, bus_en, bus_load, busy);
            end else pass_cnt++;
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0010;
        src[5:3] = 3'd2;
        dst[5:3] = 3'd5;
        @(negedge clk);
        total_cnt++;
        if ({bus_en, bus_load, ack, busy} !== {8'h04, 8'h00, 4'b0000, 1'b1}) begin
            $display("FAIL single_drive: bus_en=%h bus_load=%h ack=%b busy=%b, want 04 00 0000 1",
                     bus_en, bus_load, ack, busy);
        end else pass_cnt++;
        req = 4'b0000;
        @(negedge clk);
        total_cnt++;
        if ({bus_en, bus_load, ack, busy} !== {8'h04, 8'h20, 4'b0010, 1'b1}) begin
            $display("FAIL single_load: bus_en=%h bus_load=%h ack=%b busy=%b, want 04 20 0010 1",
                     bus_en, bus_load, ack, busy);
        end else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({bus_en, bus_load, ack, busy} !== 21'd0) begin
            $display("FAIL single_done: bus_en=%h bus_load=%h ack=%b busy=%b, want all 0",
                     bus_en, bus_load, ack, busy);
        end else pass_cnt++;
        total_cnt++;
        if (regs[5] !== 16'hBEEF) begin
            $display("FAIL single_copy: reg5=%h want beef", regs[5]);
        end else pass_cnt++;
    endtask

    task automatic test_arbitration();
        int cyc;
        int last_cyc;
        logic [3:0] exp_ack;
        logic [7:0] exp_en;
        logic [7:0] exp_ld;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src[i*3 +: 3] = 3'(i);
            dst[i*3 +: 3] = 3'(i + 4);
        end
        req = 4'b1111;
        cyc = 0;
        last_cyc = -1;
        for (int n = 0; n < 4; n++) begin
            for (int w = 0; w < 10; w++) begin
                @(negedge clk);
                cyc++;
                if (ack !== 4'b0000) break;
            end
`ifdef BUSSEQ_FIXED_PRIORITY_EN
            exp_ack = 4'b0001;
            exp_en  = 8'h01;
            exp_ld  = 8'h10;
`else
            exp_ack = 4'b0001 << n;
            exp_en  = 8'h01 << n;
            exp_ld  = 8'h10 << n;
`endif
            total_cnt++;
            if ({ack, bus_en, bus_load} !== {exp_ack, exp_en, exp_ld}) begin
                $display("FAIL arb_grant[%0d]: ack=%b bus_en=%h bus_load=%h, want %b %h %h",
                         n, ack, bus_en, bus_load, exp_ack, exp_en, exp_ld);
            end else pass_cnt++;
            total_cnt++;
            if ((n == 0 && cyc !== 2) || (n != 0 && (cyc - last_cyc) !== 3)) begin
                $display("FAIL arb_timing[%0d]: ack at cycle %0d (prev %0d), want first at 2 then +3",
                         n, cyc, last_cyc);
            end else pass_cnt++;
            last_cyc = cyc;
`ifndef BUSSEQ_FIXED_PRIORITY_EN
            req = req & ~ack;
`endif
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_out_of_range();
        do_reset();
        req2 = 4'b0001;
        src2[2:0] = 3'd7;
        dst2[2:0] = 3'd2;
        @(negedge clk);
        total_cnt++;
        if ({bus_en2, bus_load2, ack2, busy2} !== {6'h00, 8'h00, 4'b0000, 1'b1}) begin
            $display("FAIL oor_drive: bus_en=%h bus_load=%h ack=%b busy=%b, want 00 00 0000 1",
                     bus_en2, bus_load2, ack2, busy2);
        end else pass_cnt++;
        req2 = 4'b0000;
        @(negedge clk);
        total_cnt++;
        if ({bus_en2, bus_load2, ack2, busy2} !== {6'h00, 8'h04, 4'b0001, 1'b1}) begin
            $display("FAIL oor_load: bus_en=%h bus_load=%h ack=%b busy=%b, want 00 04 0001 1",
                     bus_en2, bus_load2, ack2, busy2);
        end else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({bus_en2, bus_load2, ack2, busy2} !== 19'd0) begin
            $display("FAIL oor_done: bus_en=%h bus_load=%h ack=%b busy=%b, want all 0",
                     bus_en2, bus_load2, ack2, busy2);
        end else pass_cnt++;
    endtask

    task automatic test_reset_in_drive();
        do_reset();
        req = 4'b0100;
        src[8:6] = 3'd1;
        dst[8:6] = 3'd3;
        @(negedge clk);
        total_cnt++;
        if ({bus_en, busy} !== {8'h02, 1'b1}) begin
            $display("FAIL rst_drive_pre: bus_en=%h busy=%b, want 02 1", bus_en, busy);
        end else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({bus_en, bus_load, ack, busy} !== 21'd0) begin
            $display("FAIL rst_drive_abort: bus_en=%h bus_load=%h ack=%b busy=%b, want all 0",
                     bus_en, bus_load, ack, busy);
        end else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({bus_en, bus_load, ack, busy} !== {8'h02, 8'h00, 4'b0000, 1'b1}) begin
            $display("FAIL rst_restart_drive: bus_en=%h bus_load=%h ack=%b busy=%b, want 02 00 0000 1",
                     bus_en, bus_load, ack, busy);
        end else pass_cnt++;
        req = 4'b0000;
        @(negedge clk);
        total_cnt++;
        if ({bus_en, bus_load, ack, busy} !== {8'h02, 8'h08, 4'b0100, 1'b1}) begin
            $display("FAIL rst_restart_load: bus_en=%h bus_load=%h ack=%b busy=%b, want 02 08 0100 1",
                     bus_en, bus_load, ack, busy);
        end else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({bus_en, bus_load, ack, busy} !== 21'd0) begin
            $display("FAIL rst_restart_done: bus_en=%h bus_load=%h ack=%b busy=%b, want all 0",
                     bus_en, bus_load, ack, busy);
        end else pass_cnt++;
    endtask

    task automatic test_random();
        logic       prev_busy, prev2_busy;
        logic [3:0] prev_ack, req_d1, req_d2;
        logic [7:0] prev_en, prev_ld;
        logic       ok;
        do_reset();
        prev_busy = 1'b0; prev2_busy = 1'b0;
        prev_ack = '0; prev_en = '0; prev_ld = '0;
        req_d1 = '0; req_d2 = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ok = ($countones(bus_en) <= 1) && ($countones(bus_load) <= 1) &&
                 ($countones(ack) <= 1) && (bus_load == 8'h00 || bus_en != 8'h00);
            total_cnt++;
            if (ok !== 1'b1) begin
                $display("FAIL rnd_invariant[%0d]: ack=%b bus_en=%h bus_load=%h", c, ack, bus_en, bus_load);
            end else pass_cnt++;
            if (ack != 4'b0000) begin
                ok = prev_busy && !prev2_busy && (prev_ack == 4'b0000) && (prev_ld == 8'h00) &&
                     (prev_en == bus_en) && busy && ((ack & req_d2) == ack);
                total_cnt++;
                if (ok !== 1'b1) begin
                    $display("FAIL rnd_ack_seq[%0d]: ack=%b bus_en=%h prev_en=%h prev_busy=%b prev2_busy=%b req_at_grant=%b",
                             c, ack, bus_en, prev_en, prev_busy, prev2_busy, req_d2);
                end else pass_cnt++;
            end
            prev2_busy = prev_busy;
            prev_busy  = busy;
            prev_ack   = ack;
            prev_en    = bus_en;
            prev_ld    = bus_load;
            req_d2     = req_d1;
            req        = 4'($urandom_range(0, 15));
            src        = 12'($urandom);
            dst        = 12'($urandom);
            req_d1     = req;
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_out_of_range();
        test_reset_in_drive();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
